// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel count,
// select width and the per-channel slot state encoding.
package demux_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register with valid/ready handshake. The top guarantees
// load is only raised when the slot is EMPTY or draining this cycle.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    slot_state_t  state_q, state_d;
    logic [W-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A load wins over a drain, so a FULL slot can refill without a bubble.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if (state_q == SLOT_FULL && out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/demux1x4_stream.sv
// Registered 1-to-4 stream demultiplexer with independent per-channel stalls.
// Optional per-channel saturating transfer counters when DEMUX_COUNT_EN is defined.
module demux1x4_stream
    import demux_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  sel_t                 in_sel,
    output logic [NUM_OUT-1:0]   out_valid,
    input  logic [NUM_OUT-1:0]   out_ready,
    output logic [NUM_OUT*W-1:0] out_data
`ifdef DEMUX_COUNT_EN
    ,
    output logic [NUM_OUT*CW-1:0] cnt,
    input  logic                  cnt_clr
`endif
);

    logic               accept;
    logic [NUM_OUT-1:0] load;

    // Only the addressed channel gates acceptance; other stalled channels do not.
    assign in_ready = en && (!out_valid[in_sel] || out_ready[in_sel]);
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        assign load[k] = accept && (in_sel == sel_t'(k));

        demux_out_slot #(
            .W(W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*W +: W])
        );
    end

`ifdef DEMUX_COUNT_EN
    logic [CW-1:0] cnt_q [NUM_OUT];
    logic [CW-1:0] cnt_d [NUM_OUT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Clear has priority over a coincident handshake; counts stick at all-ones.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_clr) begin
                cnt_d[k] = '0;
            end else if (out_valid[k] && out_ready[k] && (cnt_q[k] != {CW{1'b1}})) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_cnt
        assign cnt[k*CW +: CW] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_demux1x4_stream.sv
// Directed bench for demux1x4_stream with a per-channel data scoreboard.
// Counter checks are compiled in when DEMUX_COUNT_EN is defined.
module tb_demux1x4_stream;
    import demux_pkg::*;

    localparam int W = 8;
`ifdef DEMUX_COUNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_data;
    sel_t                 in_sel;
    logic [NUM_OUT-1:0]   out_valid;
    logic [NUM_OUT-1:0]   out_ready;
    logic [NUM_OUT*W-1:0] out_data;
`ifdef DEMUX_COUNT_EN
    logic [NUM_OUT*CW-1:0] cnt;
    logic                  cnt_clr;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] sbQ [NUM_OUT][$];

    demux1x4_stream #(
        .W  (W),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt       (cnt),
        .cnt_clr   (cnt_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input int sel, input logic [W-1:0] data);
        in_valid = valid;
        in_sel   = sel_t'(sel);
        in_data  = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [W-1:0] chanData(input int k);
        return out_data[k*W +: W];
    endfunction

    // Scoreboard: pop on each output handshake, push on each accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) sbQ[k].delete();
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sbQ[k].size() == 0) begin
                        checkOutput($sformatf("sb_unexpected_ch%0d", k), 32'd1, 32'd0);
                    end else begin
                        checkOutput($sformatf("sb_data_ch%0d", k),
                                    32'(chanData(k)), 32'(sbQ[k].pop_front()));
                    end
                end
            end
            if (in_valid && in_ready) sbQ[in_sel].push_back(in_data);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        en        = 1'b0;
        out_ready = 4'h0;
        applyStimulus(1'b0, 0, 8'h00);
`ifdef DEMUX_COUNT_EN
        cnt_clr = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_in_ready_en0", 32'(in_ready), 32'h0);
        en = 1'b1;
        #1;
        checkOutput("rst_in_ready_en1", 32'(in_ready), 32'h1);
        tick();
        rst_n     = 1'b1;
        out_ready = 4'hF;

        // Single word to channel 2
        applyStimulus(1'b1, 2, 8'hA1);
        #1 checkOutput("single_in_ready", 32'(in_ready), 32'h1);
        tick();
        applyStimulus(1'b0, 0, 8'h00);
        checkOutput("single_valid", 32'(out_valid), 32'h4);
        checkOutput("single_data", 32'(chanData(2)), 32'hA1);
        tick();
        checkOutput("single_drained", 32'(out_valid), 32'h0);

        // Back-to-back words to every channel
        for (int i = 0; i < NUM_OUT; i++) begin
            applyStimulus(1'b1, i, 8'(8'h10 + i));
            #1 checkOutput($sformatf("b2b_in_ready_%0d", i), 32'(in_ready), 32'h1);
            tick();
            checkOutput($sformatf("b2b_valid_%0d", i), 32'(out_valid), 32'(1 << i));
            checkOutput($sformatf("b2b_data_%0d", i), 32'(chanData(i)), 32'(8'h10 + i));
        end
        applyStimulus(1'b0, 0, 8'h00);
        tick();
        checkOutput("b2b_drained", 32'(out_valid), 32'h0);

        // Stalled channel 1 must not block channel 3
        out_ready = 4'b1101;
        applyStimulus(1'b1, 1, 8'h55);
        tick();
        checkOutput("stall_valid_55", 32'(out_valid), 32'h2);
        applyStimulus(1'b1, 1, 8'h66);
        #1 checkOutput("stall_in_ready_ch1", 32'(in_ready), 32'h0);
        tick();
        checkOutput("stall_hold_data", 32'(chanData(1)), 32'h55);
        applyStimulus(1'b1, 3, 8'h77);
        #1 checkOutput("stall_in_ready_ch3", 32'(in_ready), 32'h1);
        tick();
        checkOutput("stall_valid_both", 32'(out_valid), 32'hA);
        checkOutput("stall_ch3_data", 32'(chanData(3)), 32'h77);
        checkOutput("stall_ch1_still", 32'(chanData(1)), 32'h55);
        applyStimulus(1'b1, 1, 8'h66);
        out_ready = 4'hF;
        #1 checkOutput("unstall_in_ready", 32'(in_ready), 32'h1);
        tick();
        applyStimulus(1'b0, 0, 8'h00);
        checkOutput("unstall_valid", 32'(out_valid), 32'h2);
        checkOutput("unstall_data_66", 32'(chanData(1)), 32'h66);
        tick();
        checkOutput("unstall_drained", 32'(out_valid), 32'h0);

        // Simultaneous drain and refill on channel 0
        applyStimulus(1'b1, 0, 8'h20);
        tick();
        checkOutput("refill_first", 32'(chanData(0)), 32'h20);
        applyStimulus(1'b1, 0, 8'h21);
        tick();
        applyStimulus(1'b0, 0, 8'h00);
        checkOutput("refill_valid", 32'(out_valid), 32'h1);
        checkOutput("refill_data", 32'(chanData(0)), 32'h21);
        tick();

        // Routing disabled
        en = 1'b0;
        applyStimulus(1'b1, 2, 8'h99);
        #1 checkOutput("en0_in_ready", 32'(in_ready), 32'h0);
        tick();
        checkOutput("en0_no_output", 32'(out_valid), 32'h0);
        applyStimulus(1'b0, 0, 8'h00);
        en = 1'b1;

        // Asynchronous reset with words held
        out_ready = 4'h0;
        applyStimulus(1'b1, 0, 8'h33);
        tick();
        applyStimulus(1'b1, 3, 8'h44);
        tick();
        applyStimulus(1'b0, 0, 8'h00);
        checkOutput("held_before_reset", 32'(out_valid), 32'h9);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'h0);
        checkOutput("async_rst_data", out_data, 32'h0);
        checkOutput("async_rst_in_ready", 32'(in_ready), 32'h1);
        tick();
        rst_n     = 1'b1;
        out_ready = 4'hF;
        tick();

`ifdef DEMUX_COUNT_EN
        // Saturation: 17 handshakes on channel 2 with a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 2, 8'(8'hC0 + i));
            tick();
        end
        applyStimulus(1'b0, 0, 8'h00);
        tick();
        tick();
        checkOutput("cnt_saturated", 32'(cnt[2*CW +: CW]), 32'd15);
        checkOutput("cnt_ch0_idle", 32'(cnt[0*CW +: CW]), 32'd0);
        applyStimulus(1'b1, 2, 8'hEE);
        tick();
        applyStimulus(1'b0, 0, 8'h00);
        cnt_clr = 1'b1;
        #1 checkOutput("clr_handshake_pending", 32'(out_valid), 32'h4);
        tick();
        cnt_clr = 1'b0;
        checkOutput("cnt_clear_wins", 32'(cnt[2*CW +: CW]), 32'd0);
        tick();
`endif

        for (int k = 0; k < NUM_OUT; k++) begin
            checkOutput($sformatf("sb_empty_ch%0d", k), 32'(sbQ[k].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
